// File: rtl/stoch_decoder.sv
// stoch_decoder: recovers a probability from a stochastic bitstream by
// counting ones over a window of n2 valid samples, with a valid/ready
// result handshake.
// Optional feature: define STOCH_DEC_CONTINUOUS_EN for back-to-back windows
// (no HOLD state, result overwrite with sticky overrun flag).
module stoch_decoder #(
  parameter int n  = 7,
  parameter int n2 = 2**n
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       prob_bit,
  output logic [7:0] probability,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  localparam logic [n:0] LAST = (n+1)'(n2 - 1);

  state_t     state_q;
  logic [n:0] sample_cnt_q;
  logic [n:0] ones_cnt_q;
  logic [7:0] probability_q;
  logic       out_valid_q;
  logic       busy_q;
  logic [n:0] ones_next;
  logic       accept;
`ifdef STOCH_DEC_CONTINUOUS_EN
  logic       overrun_q;
`endif

  // Ones count including the current sample, and result handshake strobe.
  always_comb begin
    ones_next = ones_cnt_q + (n+1)'(prob_bit);
    accept    = out_valid_q & out_ready;
  end

  // Window FSM with counters and registered outputs; clear overrides all inputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      ones_cnt_q    <= '0;
      probability_q <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef STOCH_DEC_CONTINUOUS_EN
      overrun_q     <= 1'b0;
`endif
    end else if (clear) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef STOCH_DEC_CONTINUOUS_EN
      overrun_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= COUNT;
            sample_cnt_q <= '0;
            ones_cnt_q   <= '0;
            busy_q       <= 1'b1;
          end
        end
        COUNT: begin
`ifdef STOCH_DEC_CONTINUOUS_EN
          if (accept) out_valid_q <= 1'b0;
`endif
          if (bit_valid) begin
            if (sample_cnt_q == LAST) begin
              // Last sample is folded in directly so the result lands one
              // cycle after it, while the counters restart from zero.
              probability_q <= 8'(ones_next);
              out_valid_q   <= 1'b1;
              sample_cnt_q  <= '0;
              ones_cnt_q    <= '0;
`ifdef STOCH_DEC_CONTINUOUS_EN
              if (out_valid_q && !out_ready) overrun_q <= 1'b1;
`else
              state_q       <= HOLD;
              busy_q        <= 1'b0;
`endif
            end else begin
              sample_cnt_q <= sample_cnt_q + 1'b1;
              ones_cnt_q   <= ones_next;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign probability = probability_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
`ifdef STOCH_DEC_CONTINUOUS_EN
  assign overrun     = overrun_q;
`else
  assign overrun     = 1'b0;
`endif

endmodule
